// File: rtl/hamming_7_4_pkg.sv
// Shared constants and helpers for the Hamming(7,4) SEC decoder.
// Hamming position k lives at code[8-k].
package hamming_7_4_pkg;

    localparam int P1 = 7;
    localparam int P2 = 6;
    localparam int D1 = 5;
    localparam int P4 = 4;
    localparam int D2 = 3;
    localparam int D3 = 2;
    localparam int D4 = 1;

    function automatic logic [3:1] syndrome(input logic [7:1] code);
        logic s1, s2, s3;
        s1 = code[P1] ^ code[D1] ^ code[D2] ^ code[D4];
        s2 = code[P2] ^ code[D1] ^ code[D3] ^ code[D4];
        s3 = code[P4] ^ code[D2] ^ code[D3] ^ code[D4];
        return {s3, s2, s1};
    endfunction

    function automatic logic [4:1] extract_data(input logic [7:1] code);
        return {code[D1], code[D2], code[D3], code[D4]};
    endfunction

endpackage

// File: rtl/hamming_7_4_decoder_if.sv
// Codeword-in / corrected-data-out bundle for the Hamming(7,4) decoder.
interface hamming_7_4_decoder_if;

    logic       valid_in;
    logic [7:1] code_in;
    logic       valid_out;
    logic [4:1] data_out;
    logic       error;
    logic [3:1] syndrome;

    modport master (
        output valid_in, code_in,
        input  valid_out, data_out, error, syndrome
    );

    modport slave (
        input  valid_in, code_in,
        output valid_out, data_out, error, syndrome
    );

endinterface

// File: rtl/hamming_7_4_syndrome.sv
// Combinational syndrome {s3,s2,s1} of a received 7-bit codeword.
module hamming_7_4_syndrome
    import hamming_7_4_pkg::*;
(
    input  logic [7:1] code_in,
    output logic [3:1] syn_out
);

    assign syn_out = syndrome(code_in);

endmodule

// File: rtl/hamming_7_4_decoder.sv
// Hamming(7,4) single-error-correcting decoder with registered outputs.
// Double errors miscorrect silently; only SEC is provided.
module hamming_7_4_decoder
    import hamming_7_4_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    hamming_7_4_decoder_if.slave   dec_if
);

    logic [3:1] syn_c;
    logic [7:1] flip_mask;
    logic [7:1] corr_c;

    logic       valid_d, valid_q;
    logic [4:1] data_d,  data_q;
    logic       error_d, error_q;
    logic [3:1] syn_d,   syn_q;

    hamming_7_4_syndrome u_syndrome (
        .code_in (dec_if.code_in),
        .syn_out (syn_c)
    );

    // Syndrome value S selects Hamming position S, i.e. code bit 8-S.
    always_comb begin
        flip_mask = '0;
        case (syn_c)
            3'd1: flip_mask[P1] = 1'b1;
            3'd2: flip_mask[P2] = 1'b1;
            3'd3: flip_mask[D1] = 1'b1;
            3'd4: flip_mask[P4] = 1'b1;
            3'd5: flip_mask[D2] = 1'b1;
            3'd6: flip_mask[D3] = 1'b1;
            3'd7: flip_mask[D4] = 1'b1;
            default: flip_mask = '0;
        endcase
        corr_c = dec_if.code_in ^ flip_mask;
    end

    always_comb begin
        valid_d = dec_if.valid_in;
        data_d  = data_q;
        error_d = error_q;
        syn_d   = syn_q;
        if (dec_if.valid_in) begin
            data_d  = extract_data(corr_c);
            error_d = (syn_c != 3'd0);
            syn_d   = syn_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            error_q <= 1'b0;
            syn_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            error_q <= error_d;
            syn_q   <= syn_d;
        end
    end

    assign dec_if.valid_out = valid_q;
    assign dec_if.data_out  = data_q;
    assign dec_if.error     = error_q;
    assign dec_if.syndrome  = syn_q;

endmodule

// File: tb/tb_hamming_7_4_decoder.sv
// Directed bench for hamming_7_4_decoder: reset, clean/error words, single-error sweep, hold.
module tb_hamming_7_4_decoder;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    hamming_7_4_decoder_if dec_if ();

    hamming_7_4_decoder dut (
        .clk    (clk),
        .rst    (rst),
        .dec_if (dec_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read one falling edge later.
    task automatic step(input logic v, input logic [7:1] code);
        dec_if.valid_in = v;
        dec_if.code_in  = code;
        @(negedge clk);
    endtask

    function automatic logic [7:1] encode(input logic [4:1] d);
        logic d1, d2, d3, d4;
        {d1, d2, d3, d4} = d;
        return {d1 ^ d2 ^ d4, d1 ^ d3 ^ d4, d1, d2 ^ d3 ^ d4, d2, d3, d4};
    endfunction

    typedef struct {
        logic [7:1] code;
        logic [4:1] data;
        logic       err;
        logic [3:1] syn;
    } vec_t;

    vec_t vecs[6];

    initial begin
        n_cmp = 0;
        n_err = 0;
        vecs[0] = '{7'b0111100, 4'b1100, 1'b0, 3'd0};
        vecs[1] = '{7'b1011010, 4'b1010, 1'b0, 3'd0};
        vecs[2] = '{7'b1101001, 4'b0001, 1'b0, 3'd0};
        vecs[3] = '{7'b0101010, 4'b0010, 1'b0, 3'd0};
        vecs[4] = '{7'b0111000, 4'b1100, 1'b1, 3'd5};
        vecs[5] = '{7'b1010010, 4'b1010, 1'b1, 3'd4};

        rst = 1'b1;
        dec_if.valid_in = 1'b0;
        dec_if.code_in  = '0;
        @(negedge clk);
        step(1'b0, 7'b0);
        chk("rst_valid", {7'b0, dec_if.valid_out}, 8'd0);
        chk("rst_data",  {4'b0, dec_if.data_out},  8'd0);
        chk("rst_error", {7'b0, dec_if.error},     8'd0);
        chk("rst_syn",   {5'b0, dec_if.syndrome},  8'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(1'b1, vecs[i].code);
            chk("dir_valid", {7'b0, dec_if.valid_out}, 8'd1);
            chk("dir_data",  {4'b0, dec_if.data_out},  {4'b0, vecs[i].data});
            chk("dir_error", {7'b0, dec_if.error},     {7'b0, vecs[i].err});
            chk("dir_syn",   {5'b0, dec_if.syndrome},  {5'b0, vecs[i].syn});
        end

        // Hold: last result was the position-4 parity error word.
        step(1'b0, 7'b1111111);
        chk("hold_valid", {7'b0, dec_if.valid_out}, 8'd0);
        chk("hold_data",  {4'b0, dec_if.data_out},  8'b1010);
        chk("hold_error", {7'b0, dec_if.error},     8'd1);
        chk("hold_syn",   {5'b0, dec_if.syndrome},  8'd4);
        step(1'b0, 7'b0000001);
        chk("hold2_data", {4'b0, dec_if.data_out},  8'b1010);

        // Back-to-back: clean encoded words then every single-bit flip.
        for (int d = 0; d < 16; d++) begin
            logic [7:1] cw;
            cw = encode(4'(d));
            step(1'b1, cw);
            chk("clean_data", {4'b0, dec_if.data_out}, 8'(d));
            chk("clean_err",  {7'b0, dec_if.error},    8'd0);
            for (int k = 1; k <= 7; k++) begin
                logic [7:1] bad;
                bad = cw;
                bad[8 - k] = ~bad[8 - k];
                step(1'b1, bad);
                chk("sweep_valid", {7'b0, dec_if.valid_out}, 8'd1);
                chk("sweep_data",  {4'b0, dec_if.data_out},  8'(d));
                chk("sweep_err",   {7'b0, dec_if.error},     8'd1);
                chk("sweep_syn",   {5'b0, dec_if.syndrome},  8'(k));
            end
        end

        // Reset beats a simultaneous valid word.
        rst = 1'b1;
        step(1'b1, 7'b0111000);
        chk("rstv_valid", {7'b0, dec_if.valid_out}, 8'd0);
        chk("rstv_data",  {4'b0, dec_if.data_out},  8'd0);
        chk("rstv_error", {7'b0, dec_if.error},     8'd0);
        chk("rstv_syn",   {5'b0, dec_if.syndrome},  8'd0);
        rst = 1'b0;
        step(1'b1, 7'b1101001);
        chk("post_rst_data",  {4'b0, dec_if.data_out}, 8'b0001);
        chk("post_rst_valid", {7'b0, dec_if.valid_out}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
